// File: rtl/clock_display_mux.sv
// clock_display_mux: 4-digit multiplexed 7-segment driver for a 12-hour HH:MM clock.
// The time is shadowed once per scan frame so one frame never mixes old and new digits.
// Each digit slot opens with a dark gap, which suppresses ghosting between digits.
module clock_display_mux #(
  parameter int unsigned SCAN_DIV  = 1024,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic       pm,
  input  logic       tick,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       colon
);

  localparam int unsigned CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYC);

  // Scan position, shadowed time and blink state
  logic [CW-1:0] c_q, c_d;
  logic [1:0]    d_q, d_d;
  logic [7:0]    sh_hh_q, sh_hh_d;
  logic [7:0]    sh_mm_q, sh_mm_d;
  logic          sh_pm_q, sh_pm_d;
  logic          blink_q, blink_d;

  // Registered pad outputs
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          colon_q, colon_d;

  logic [3:0]    nib;
  logic          slot_end;
  logic          frame_end;
  logic          vis;

  // BCD nibble to segment pattern; anything above 9 shows a dash
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Next-state: scan counters, frame-end snapshot, colon blink
  always_comb begin
    c_d     = c_q + CW'(1);
    d_d     = d_q;
    sh_hh_d = sh_hh_q;
    sh_mm_d = sh_mm_q;
    sh_pm_d = sh_pm_q;
    blink_d = blink_q;

    slot_end  = (c_q == C_LAST);
    frame_end = slot_end && (d_q == 2'd3);

    if (slot_end) begin
      c_d = '0;
      d_d = d_q + 2'd1;
    end
    if (frame_end) begin
      sh_hh_d = hh;
      sh_mm_d = mm;
      sh_pm_d = pm;
    end
    if (tick) begin
      blink_d = ~blink_q;
    end
  end

  // Output decode for the current (c,d); registered one cycle later
  always_comb begin
    nib     = 4'd0;
    an_d    = 4'b0000;
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    colon_d = disp_en && blink_q;
    vis     = disp_en && (c_q >= C_BLANK);

    case (d_q)
      2'd0:    nib = sh_hh_q[7:4];
      2'd1:    nib = sh_hh_q[3:0];
      2'd2:    nib = sh_mm_q[7:4];
      default: nib = sh_mm_q[3:0];
    endcase

    if (vis) begin
      case (d_q)
        2'd0:    an_d = 4'b1000;
        2'd1:    an_d = 4'b0100;
        2'd2:    an_d = 4'b0010;
        default: an_d = 4'b0001;
      endcase
      // Leading hour-tens zero is blanked but the digit enable still scans
      if ((d_q == 2'd0) && (sh_hh_q[7:4] == 4'd0)) begin
        seg_d = 7'h00;
      end else begin
        seg_d = seg_decode(nib);
      end
      dp_d = (d_q == 2'd3) && sh_pm_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      d_q     <= 2'd0;
      sh_hh_q <= 8'h12;
      sh_mm_q <= 8'h00;
      sh_pm_q <= 1'b0;
      blink_q <= 1'b1;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      an_q    <= 4'b0000;
      colon_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      d_q     <= d_d;
      sh_hh_q <= sh_hh_d;
      sh_mm_q <= sh_mm_d;
      sh_pm_q <= sh_pm_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      colon_q <= colon_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign colon = colon_q;

endmodule
